// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: assembles LSB-first frames of WIDTH bits
// and presents each completed frame through a one-entry valid/ready output stage.
module sipo_deser #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shift,
  input  logic                     serial_in,
  input  logic                     clear,
  output logic [WIDTH-1:0]         parallel_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overrun,
  output logic [$clog2(WIDTH)-1:0] bit_count
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Output stage handshake: a frame is transferred on every rising clk edge
  // where out_valid and out_ready are both high; out_valid never drops without one.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-2:0] r_shreg;
  logic [WIDTH-1:0] r_pout;
  logic [CW-1:0]    r_cnt;
  logic             r_ovr;

  logic             w_complete;
  logic             w_load;
  logic             w_drop;
  logic [WIDTH-1:0] w_word;

  // Only the upper WIDTH-1 bits need storing; the incoming bit completes the word.
  assign w_word     = {serial_in, r_shreg};
  assign w_complete = shift & ~clear & (r_cnt == LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_complete) begin
          w_state_nxt = FULL;
          w_load      = 1'b1;
        end
      end
      FULL: begin
        if (w_complete) begin
          if (out_ready) w_load = 1'b1;
          else           w_drop = 1'b1;
        end else if (out_ready) begin
          w_state_nxt = EMPTY;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_pout  <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (clear) begin
        r_shreg <= '0;
        r_cnt   <= '0;
      end else if (shift) begin
        r_shreg <= w_word[WIDTH-1:1];
        r_cnt   <= w_complete ? '0 : r_cnt + 1'b1;
      end
      if (w_load) r_pout <= w_word;
      // A drop never coincides with clear, since clear suppresses completion.
      if (clear)       r_ovr <= 1'b0;
      else if (w_drop) r_ovr <= 1'b1;
    end
  end

  assign parallel_out = r_pout;
  assign out_valid    = (r_state == FULL);
  assign overrun      = r_ovr;
  assign bit_count    = r_cnt;

endmodule
